cla_seq32: RTL
==============

CLA_SEQ32 -- requirements
Module: cla_seq32

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 32 bits, processed as 8 slices of 4 bits.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled on a rising edge of clk.
REQ-005 op  input  1  operation select: 0 = add (a+b), 1 = subtract (a-b).
REQ-006 a  input  32  operand A; captured when start is accepted.
REQ-007 b  input  32  operand B; captured when start is accepted.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking result valid.
REQ-010 result  output  32  sum or difference.
REQ-011 carry  output  1  carry out of bit 31; for subtract, 1 means no borrow.
REQ-012 overflow  output  1  two's-complement signed overflow.

Function
REQ-013 The block SHALL compute the result with a single instantiated 4-bit CLA slice (cla4_ov: inputs a, b, ci; outputs s, c3, co), reused once per slice, LSB slice first.
REQ-014 The FSM SHALL have three states:
- IDLE: busy=0, done=0.
- RUN: busy=1, done=0.
- DONE: busy=0, done=1; lasts exactly one cycle.
REQ-015 Transitions SHALL be:
- IDLE or DONE, start=1 -> RUN.
- IDLE, start=0 -> IDLE.
- DONE, start=0 -> IDLE.
- RUN, slice counter = 7 -> DONE.
- RUN, otherwise -> RUN.
REQ-016 On an accepted start, the block SHALL:
- latch a into the A register;
- latch b, or ~b when op=1, into the B register;
- preload the carry register with op;
- clear the 3-bit slice counter and clear result.
REQ-017 In each RUN cycle k (k = 0..7), the block SHALL:
- drive slice inputs a[4k+3:4k], b[4k+3:4k] and ci = carry register;
- write slice output s into result[4k+3:4k];
- load co into the carry register;
- increment the counter, wrapping 7 -> 0.
REQ-018 When the counter reaches 7, the block SHALL register carry = co and overflow = c3 XOR co from that cycle.
REQ-019 Latency SHALL be fixed: start sampled at edge N -> busy high for cycles N+1..N+8 -> done high in cycle N+9; result, carry and overflow are valid in that cycle.
REQ-020 result, carry and overflow SHALL hold their values after done until the next accepted start.
REQ-021 start SHALL be ignored while in RUN; the operands and op in flight SHALL not change.
REQ-022 start asserted during the DONE cycle SHALL be accepted; busy rises the next cycle, giving back-to-back operations every 9 cycles.
REQ-023 a, b and op SHALL be sampled only on start acceptance; later changes SHALL not affect the operation in flight.

Reset
REQ-024 While reset=1, the block SHALL force:
- state = IDLE;
- busy = 0, done = 0;
- result = 0, carry = 0, overflow = 0;
- slice counter = 0, carry register = 0, A and B registers = 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation immediately with no done pulse.
REQ-026 After reset deasserts, the first start SHALL be accepted on the first rising edge.

Verification
REQ-027 add 0x7FFFFFFF + 0x00000001 -> done at start+9, result 0x80000000, carry 0, overflow 1.
REQ-028 add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, carry 1, overflow 0.
REQ-029 sub 0x00000005 - 0x00000007 -> result 0xFFFFFFFE, carry 0, overflow 0.
REQ-030 sub 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, carry 1, overflow 1.
REQ-031 start held high through RUN, with a/b changed mid-run -> single done, result from the original operands; a second operation starts from the DONE cycle; done cycles exactly 9 apart.
REQ-032 reset pulsed at RUN cycle 4 -> busy, done, result, carry and overflow all 0 next cycle; no done pulse; a new start then completes normally in 9 cycles.

Source files
------------

// File: rtl/cla_seq32.sv
// rtl/cla_seq32.sv - sequential 32-bit add/subtract built from one reused 4-bit CLA slice
//
// cla4_ov   : 4-bit carry-lookahead adder slice
//   a, b    in  [3:0]  slice operands
//   ci      in         carry in
//   s       out [3:0]  slice sum
//   c3      out        carry into bit 3 (feeds signed-overflow detection)
//   co      out        carry out of bit 3
//
// cla_seq32 : 32-bit adder/subtractor, one 4-bit slice per clock, LSB slice first
//   clk      in         system clock, rising edge
//   reset    in         asynchronous, active-high
//   start    in         request pulse, accepted in IDLE or DONE
//   op       in         0 = a+b, 1 = a-b
//   a, b     in  [31:0] operands, sampled only when start is accepted
//   busy     out        high during the 8 RUN cycles
//   done     out        one-cycle pulse, result/carry/overflow valid
//   result   out [31:0] sum or difference, held until the next accepted start
//   carry    out        carry out of bit 31 (subtract: 1 = no borrow)
//   overflow out        two's-complement signed overflow

module cla4_ov (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c3,
  output logic       co
);

  logic [3:0] p;
  logic [3:0] g;
  logic       c1;
  logic       c2;

  always_comb begin
    p  = a ^ b;
    g  = a & b;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    s  = p ^ {c3, c2, c1, ci};
  end

endmodule

module cla_seq32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        cin_q, cin_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        carry_q, carry_d;
  logic        overflow_q, overflow_d;

  logic [4:0]  slice_lsb;
  logic [3:0]  slice_a;
  logic [3:0]  slice_b;
  logic [3:0]  slice_s;
  logic        slice_c3;
  logic        slice_co;

  // The slice counter selects which nibble of the operand registers feeds the
  // single adder slice this cycle.
  always_comb begin
    slice_lsb = {cnt_q, 2'b00};
    slice_a   = a_q[slice_lsb +: 4];
    slice_b   = b_q[slice_lsb +: 4];
  end

  cla4_ov u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (cin_q),
    .s  (slice_s),
    .c3 (slice_c3),
    .co (slice_co)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          a_d      = a;
          // Subtract is a + ~b + 1: invert B here and preload the +1 as carry in.
          b_d      = op ? ~b : b;
          cin_d    = op;
          cnt_d    = 3'd0;
          result_d = 32'd0;
        end
      end
      RUN: begin
        busy                     = 1'b1;
        result_d[slice_lsb +: 4] = slice_s;
        cin_d                    = slice_co;
        cnt_d                    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d    = DONE;
          carry_d    = slice_co;
          overflow_d = slice_c3 ^ slice_co;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
        if (start) begin
          state_d  = RUN;
          a_d      = a;
          b_d      = op ? ~b : b;
          cin_d    = op;
          cnt_d    = 3'd0;
          result_d = 32'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      cin_q      <= 1'b0;
      cnt_q      <= 3'd0;
      result_q   <= 32'd0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

endmodule
